lsu_mem_master: RTL and testbench

- Core-side initiator for the data-memory port: accepts one load/store op at a time from the execute stage and drives the memory address/data/mask/strobe interface.
- Handles byte-lane placement, write-mask generation, read-data extraction and sign/zero extension, misalignment detection, and an ack timeout.
- Sits between the EXU/LSU pipeline stage and the memory model or bus. One transaction outstanding.

---
 rtl/lsu_mem_master.sv | 211 +++++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding load/store initiator for the data-memory port.
// Takes one op from the execute stage, places store bytes in their lanes and builds
// the write mask, extracts and extends load data, flags misaligned accesses, and
// aborts a bus access that waits too long for mem_ack.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   req_valid/req_ready           op handshake from the core
//   req_wen/addr/wdata/size/unsigned  op payload (store data right-aligned)
//   resp_valid/resp_ready         response handshake to the core
//   resp_rdata/resp_err           extended load data (0 for stores/errors), error flag
//   mem_raddr/mem_read            aligned read address and strobe
//   mem_waddr/mem_wdata/mem_wmask/mem_write  aligned write address, lane data, byte mask, strobe
//   mem_rdata/mem_ack             read data and completion from memory
module lsu_mem_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] mem_raddr,
    output logic        mem_read,
    output logic [63:0] mem_waddr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    output logic        mem_write,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        ERR  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              wen_q, wen_d;
    logic [63:0]       addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;

    // Next values of the registered outputs
    logic              req_ready_d, resp_valid_d;
    logic [63:0]       rdata_d;
    logic              err_d;
    logic              mem_read_d, mem_write_d;
    logic [63:0]       mem_raddr_d, mem_waddr_d, mem_wdata_d;
    logic [7:0]        mem_wmask_d;

    logic              timed_out;
    logic              strobe_d;
    logic [63:0]       sh;
    logic [63:0]       ext;

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
        case (size)
            2'd1:    misaligned = a[0];
            2'd2:    misaligned = (a[1:0] != 2'd0);
            2'd3:    misaligned = (a != 3'd0);
            default: misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'd0:    lane_mask = 8'h01 << off;
            2'd1:    lane_mask = 8'h03 << off;
            2'd2:    lane_mask = 8'h0F << off;
            default: lane_mask = 8'hFF;
        endcase
    endfunction

    // Count reaching TIMEOUT means the strobe is already dropped this cycle
    assign timed_out = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));

    // Load extraction: shift the addressed lane down, then extend by size
    always_comb begin
        sh  = mem_rdata >> {addr_q[2:0], 3'b000};
        ext = sh;
        case (size_q)
            2'd0:    ext = uns_q ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            2'd1:    ext = uns_q ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            2'd2:    ext = uns_q ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: ext = sh;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = resp_rdata;
        err_d   = resp_err;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    state_d = misaligned(req_size, req_addr[2:0]) ? ERR : BUS;
                end
            end
            BUS: begin
                // Timeout wins over a late ack: the strobe is no longer asserted
                if (timed_out) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (mem_ack) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    rdata_d = wen_q ? 64'd0 : ext;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ERR: begin
                state_d = RESP;
                err_d   = 1'b1;
                rdata_d = '0;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                    rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        strobe_d     = (state_d == BUS) &&
                       !((TIMEOUT != 0) && (cnt_d == CNT_W'(TIMEOUT)));
        mem_read_d   = strobe_d && !wen_d;
        mem_write_d  = strobe_d && wen_d;
        mem_raddr_d  = mem_read_d  ? {addr_d[63:3], 3'b000} : 64'd0;
        mem_waddr_d  = mem_write_d ? {addr_d[63:3], 3'b000} : 64'd0;
        mem_wdata_d  = mem_write_d ? (wdata_d << {addr_d[2:0], 3'b000}) : 64'd0;
        mem_wmask_d  = mem_write_d ? lane_mask(size_d, addr_d[2:0]) : 8'd0;
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
    end

    // State, op latches and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_raddr  <= '0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= rdata_d;
            resp_err   <= err_d;
            mem_read   <= mem_read_d;
            mem_write  <= mem_write_d;
            mem_raddr  <= mem_raddr_d;
            mem_waddr  <= mem_waddr_d;
            mem_wdata  <= mem_wdata_d;
            mem_wmask  <= mem_wmask_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: expected responses go into a scoreboard queue
// when an op is issued and are popped when resp_valid appears.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;
    logic [63:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, mem_ack;
    logic [7:0]  mem_wmask;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    lsu_mem_master #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_raddr(mem_raddr), .mem_read(mem_read),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one op for a single cycle; returns one cycle after the accept edge
    task automatic issue(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [1:0] size, input logic uns);
        req_wen = wen; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns; req_valid = 1'b1;
        check("req_ready_idle", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
    endtask

    // Act as memory until resp_valid, then compare against the scoreboard head
    task automatic run_op(input string tag, input int ack_after, input logic [63:0] exp_addr,
                          input logic [63:0] exp_wdata, input logic [7:0] exp_mask,
                          input int exp_lat, input int exp_strobes);
        int   lat = 1;
        int   strobes = 0;
        exp_t e;
        while (!resp_valid && lat < 64) begin
            check({tag, "_excl"}, 64'(mem_read & mem_write), 64'd0);
            check({tag, "_ready_busy"}, 64'(req_ready), 64'd0);
            if (mem_read) check({tag, "_raddr"}, mem_raddr, exp_addr);
            if (mem_write) begin
                check({tag, "_waddr"}, mem_waddr, exp_addr);
                check({tag, "_wdata"}, mem_wdata, exp_wdata);
                check({tag, "_wmask"}, 64'(mem_wmask), 64'(exp_mask));
            end else begin
                check({tag, "_wzero"}, {mem_wdata[55:0], mem_wmask}, 64'd0);
            end
            if (mem_read || mem_write) begin
                strobes++;
                mem_ack = (ack_after >= 0) && (strobes > ack_after);
            end
            step();
            lat++;
        end
        if (!resp_valid) begin
            errors++;
            checks++;
            $error("FAIL %s_no_resp: observed no resp_valid expected resp within 64 cycles", tag);
        end else begin
            check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
            check({tag, "_strobes"}, 64'(strobes), 64'(exp_strobes));
            check({tag, "_strobe_off"}, 64'(mem_read | mem_write), 64'd0);
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $error("FAIL %s_sb_empty: observed empty scoreboard expected entry", tag);
            end else begin
                e = sb.pop_front();
                check({tag, "_rdata"}, resp_rdata, e.rdata);
                check({tag, "_err"}, 64'(resp_err), 64'(e.err));
            end
        end
    endtask

    // Hold the response for some cycles, then consume it
    task automatic consume(input string tag, input int hold);
        logic [63:0] rd;
        logic        er;
        rd = resp_rdata;
        er = resp_err;
        resp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, "_hold_valid"}, 64'(resp_valid), 64'd1);
            check({tag, "_hold_rdata"}, {resp_rdata[62:0], resp_err}, {rd[62:0], er});
            check({tag, "_hold_ready"}, 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        check({tag, "_ready_at_handshake"}, 64'(req_ready), 64'd0);
        step();
        resp_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(resp_valid), 64'd0);
        check({tag, "_ready_back"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = '0; req_unsigned = 1'b0; resp_ready = 1'b0;
        mem_rdata = '0; mem_ack = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_strobes", 64'({mem_read, mem_write}), 64'd0);
        check("rst_rdata", resp_rdata, 64'd0);
        check("rst_wmask", 64'(mem_wmask), 64'd0);
        rst = 1'b0;
        step();

        // Signed byte load, ack tied high
        mem_rdata = 64'h0000_0000_8F00_0000;
        mem_ack   = 1'b1;
        sb.push_back('{64'hFFFF_FFFF_FFFF_FF8F, 1'b0});
        issue(1'b0, 64'h8000_0003, 64'd0, 2'd0, 1'b0);
        run_op("ldb", 0, 64'h8000_0000, 64'd0, 8'h00, 2, 1);
        consume("ldb", 0);

        // Half store into the top lanes
        mem_ack = 1'b0;
        sb.push_back('{64'd0, 1'b0});
        issue(1'b1, 64'h8000_0006, 64'h0000_0000_0000_1234, 2'd1, 1'b0);
        run_op("sth", 0, 64'h8000_0000, 64'h1234_0000_0000_0000, 8'hC0, 2, 1);
        consume("sth", 1);

        // Unsigned word load, ack after 3 wait cycles
        mem_ack   = 1'b0;
        mem_rdata = 64'hDEAD_BEEF_0000_0000;
        sb.push_back('{64'h0000_0000_DEAD_BEEF, 1'b0});
        issue(1'b0, 64'h8000_0004, 64'd0, 2'd2, 1'b1);
        run_op("ldwu", 3, 64'h8000_0000, 64'd0, 8'h00, 5, 4);
        consume("ldwu", 0);

        // Signed half load, one wait cycle
        mem_ack   = 1'b0;
        mem_rdata = 64'h0000_0000_8001_0000;
        sb.push_back('{64'hFFFF_FFFF_FFFF_8001, 1'b0});
        issue(1'b0, 64'h8000_0012, 64'd0, 2'd1, 1'b0);
        run_op("ldh", 1, 64'h8000_0010, 64'd0, 8'h00, 3, 2);
        consume("ldh", 0);

        // Misaligned dword load; ack held high must be ignored
        mem_ack   = 1'b1;
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        sb.push_back('{64'd0, 1'b1});
        issue(1'b0, 64'h8000_0004, 64'd0, 2'd3, 1'b0);
        run_op("mis", 0, 64'h8000_0000, 64'd0, 8'h00, 2, 0);
        consume("mis", 0);

        // Timeout, then a response held for 5 cycles
        mem_ack = 1'b0;
        sb.push_back('{64'd0, 1'b1});
        issue(1'b0, 64'h8000_0020, 64'd0, 2'd3, 1'b0);
        run_op("tmo", -1, 64'h8000_0020, 64'd0, 8'h00, 18, 16);
        consume("tmo", 5);

        // Reset in the second ack-wait cycle abandons the op
        mem_ack = 1'b0;
        issue(1'b0, 64'h8000_0010, 64'd0, 2'd3, 1'b0);
        step();
        check("rstbus_read_before", 64'(mem_read), 64'd1);
        rst = 1'b1;
        #1;
        check("rstbus_read", 64'(mem_read), 64'd0);
        check("rstbus_valid", 64'(resp_valid), 64'd0);
        check("rstbus_ready", 64'(req_ready), 64'd1);
        step();
        rst = 1'b0;
        step();
        check("rstbus_idle_valid", 64'(resp_valid), 64'd0);

        // Clean dword load after the reset
        mem_rdata = 64'h0123_4567_89AB_CDEF;
        sb.push_back('{64'h0123_4567_89AB_CDEF, 1'b0});
        issue(1'b0, 64'h8000_0008, 64'd0, 2'd3, 1'b0);
        run_op("ldd", 0, 64'h8000_0008, 64'd0, 8'h00, 2, 1);
        consume("ldd", 0);

        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
